// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-beat instruction fetch stage between core PC and imem port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_INST = 32'h00100073,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_in,
   input  logic             pc_valid,
   input  logic             flush,
   output logic [31:0]      inst_out,
   output logic [31:0]      inst_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [31:0]      imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             imem_rsp_err,
   output logic             fetch_err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] fetch_cnt
);

   localparam int                 c_timer_w  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_DROP = 3'd3,
      S_HOLD = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t               r_state;
   logic [31:0]          r_addr;
   logic [31:0]          r_data;
   logic [1:0]           r_err_code;
   logic [c_timer_w-1:0] r_timer;
   logic [CNT_W-1:0]     r_fetch_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_err_code  <= 2'd0;
         r_timer     <= '0;
         r_fetch_cnt <= '0;
      end else begin
         case (r_state)
            // HOLD shares the IDLE dispatch once its word is accepted
            S_IDLE, S_HOLD: begin
               if (r_state == S_HOLD && flush) begin
                  r_state <= S_IDLE;
               end else if (r_state == S_IDLE || inst_ready) begin
                  if (r_state == S_HOLD)
                     r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                  if (pc_valid) begin
                     r_addr <= pc_in;
                     if (pc_in[1:0] != 2'b00) begin
                        r_state    <= S_ERR;
                        r_err_code <= 2'd1;
                     end else begin
                        r_state <= S_REQ;
                     end
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_REQ: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else if (imem_req_ready) begin
                  r_state <= S_WAIT;
                  r_timer <= '0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid && flush) begin
                  r_state <= S_IDLE;
               end else if (imem_rsp_valid && !imem_rsp_err) begin
                  r_data  <= imem_rsp_data;
                  r_state <= S_HOLD;
               end else if (imem_rsp_valid) begin
                  r_state    <= S_ERR;
                  r_err_code <= 2'd2;
               end else if (flush) begin
                  r_state <= S_DROP;
               end else if (r_timer == c_timer_max) begin
                  r_state    <= S_ERR;
                  r_err_code <= 2'd3;
               end else begin
                  r_timer <= r_timer + c_timer_w'(1);
               end
            end
            S_DROP: begin
               if (imem_rsp_valid)
                  r_state <= S_IDLE;
            end
            S_ERR: begin
               if (inst_ready || flush) begin
                  r_state    <= S_IDLE;
                  r_err_code <= 2'd0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req_valid = (r_state == S_REQ);
   assign imem_addr      = (r_state == S_REQ) ? r_addr : 32'd0;
   assign inst_valid     = (r_state == S_HOLD) || (r_state == S_ERR);
   assign inst_out       = (r_state == S_ERR)  ? ERR_INST :
                           (r_state == S_HOLD) ? r_data   : 32'd0;
   assign inst_pc        = inst_valid ? r_addr : 32'd0;
   assign fetch_err      = (r_state == S_ERR);
   assign err_code       = r_err_code;
   assign fetch_cnt      = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        flush;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        fetch_err;
   logic [1:0]  err_code;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   ifu_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .flush          (flush),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .fetch_err      (fetch_err),
      .err_code       (err_code),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // From IDLE with req_ready=1: REQ, WAIT, then a response one cycle later
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
      pc_in    = a;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      step();
      imem_rsp_valid = 1'b0;
   endtask

   initial begin
      reset          = 1'b0;
      pc_in          = 32'd0;
      pc_valid       = 1'b0;
      flush          = 1'b0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      imem_rsp_err   = 1'b0;
      step();
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst_out", inst_out, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      reset = 1'b1;
      step();

      // T1: basic fetch, latency 3
      pc_in    = 32'h8000_0000;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      chk("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t1_req_addr", imem_addr, 32'h8000_0000);
      step();
      chk("t1_req_done", {31'd0, imem_req_valid}, 32'd0);
      chk("t1_no_early_valid", {31'd0, inst_valid}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      step();
      imem_rsp_valid = 1'b0;
      chk("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_inst_out", inst_out, 32'h0050_0093);
      chk("t1_inst_pc", inst_pc, 32'h8000_0000);
      chk("t1_cnt_before", fetch_cnt, 32'd0);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t1_fetch_cnt", fetch_cnt, 32'd1);
      chk("t1_valid_clear", {31'd0, inst_valid}, 32'd0);

      // T2: request held while req_ready is low
      imem_req_ready = 1'b0;
      pc_in          = 32'h8000_0004;
      pc_valid       = 1'b1;
      step();
      pc_valid = 1'b0;
      pc_in    = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         chk("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
         chk("t2_req_addr", imem_addr, 32'h8000_0004);
         step();
      end
      imem_req_ready = 1'b1;
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00a0_0113;
      step();
      imem_rsp_valid = 1'b0;
      chk("t2_inst_out", inst_out, 32'h00a0_0113);
      chk("t2_inst_pc", inst_pc, 32'h8000_0004);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t2_fetch_cnt", fetch_cnt, 32'd2);

      // T3: misaligned PC
      pc_in    = 32'h8000_0002;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      chk("t3_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("t3_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("t3_inst_out", inst_out, 32'h0010_0073);
      chk("t3_inst_pc", inst_pc, 32'h8000_0002);
      chk("t3_fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("t3_err_code", {30'd0, err_code}, 32'd1);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t3_err_clear", {30'd0, err_code}, 32'd0);
      chk("t3_ferr_clear", {31'd0, fetch_err}, 32'd0);
      chk("t3_cnt_same", fetch_cnt, 32'd2);

      // T4: timeout after 16 WAIT cycles, then bus error
      pc_in    = 32'h8000_0008;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      for (int i = 0; i < 15; i++) step();
      chk("t4_not_yet", {31'd0, fetch_err}, 32'd0);
      step();
      chk("t4_timeout_err", {31'd0, fetch_err}, 32'd1);
      chk("t4_timeout_code", {30'd0, err_code}, 32'd3);
      chk("t4_timeout_inst", inst_out, 32'h0010_0073);
      chk("t4_timeout_pc", inst_pc, 32'h8000_0008);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      pc_in    = 32'h8000_000c;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = 1'b1;
      imem_rsp_data  = 32'hffff_ffff;
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      chk("t4_bus_code", {30'd0, err_code}, 32'd2);
      chk("t4_bus_inst", inst_out, 32'h0010_0073);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t4_flush_clear", {31'd0, inst_valid}, 32'd0);
      chk("t4_cnt_same", fetch_cnt, 32'd2);

      // T5: flush in WAIT, late response discarded in DROP
      pc_in    = 32'h8000_0014;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      chk("t5_drop_novalid", {31'd0, inst_valid}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hdead_beef;
      step();
      imem_rsp_valid = 1'b0;
      chk("t5_after_drop", {31'd0, inst_valid}, 32'd0);
      do_fetch(32'h8000_0010, 32'h0020_8133);
      chk("t5_fresh_inst", inst_out, 32'h0020_8133);
      chk("t5_fresh_pc", inst_pc, 32'h8000_0010);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t5_fetch_cnt", fetch_cnt, 32'd3);

      // flush beats req_ready in REQ
      pc_in    = 32'h8000_0018;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("req_flush_noreq", {31'd0, imem_req_valid}, 32'd0);
      chk("req_flush_novalid", {31'd0, inst_valid}, 32'd0);

      // T6: ten back-to-back fetches from a fresh reset
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      do_fetch(32'h8000_0100, 32'h0000_1000);
      for (int i = 1; i < 10; i++) begin
         inst_ready = 1'b1;
         pc_in      = 32'h8000_0100 + 32'(4 * i);
         pc_valid   = 1'b1;
         step();
         inst_ready = 1'b0;
         pc_valid   = 1'b0;
         chk("t6_b2b_req", {31'd0, imem_req_valid}, 32'd1);
         step();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'h0000_1000 + 32'(i);
         step();
         imem_rsp_valid = 1'b0;
         chk("t6_b2b_inst", inst_out, 32'h0000_1000 + 32'(i));
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t6_fetch_cnt", fetch_cnt, 32'd10);

      // reset mid-WAIT, late response ignored
      pc_in    = 32'h8000_0200;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("midrst_cnt", fetch_cnt, 32'd0);
      chk("midrst_inst_out", inst_out, 32'd0);
      chk("midrst_req", {31'd0, imem_req_valid}, 32'd0);
      chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
      step();
      reset = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0bad_0bad;
      step();
      imem_rsp_valid = 1'b0;
      step();
      chk("late_rsp_ignored", {31'd0, inst_valid}, 32'd0);
      chk("late_rsp_out", inst_out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
